window_gen: RTL
===============

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 540, pixels per row (min 3).
REQ-003 SHALL have parameter IMG_H, default 540, rows per frame (min 3).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port clear_i  input  1  synchronous frame flush.
REQ-007 SHALL have port data_i  input  DATA_W  raster-order pixel.
REQ-008 SHALL have port data_en_i  input  1  pixel valid.
REQ-009 SHALL have port data_rdy_o  output  1  pixel accepted when data_en_i&&data_rdy_o.
REQ-010 SHALL have port win_o  output  9*DATA_W  3x3 window; element (i,j) at bits [(3*i+j)*DATA_W +: DATA_W]; i=0 oldest row, j=0 leftmost column.
REQ-011 SHALL have port win_row_o  output  clog2(IMG_H)  top-left row of window.
REQ-012 SHALL have port win_col_o  output  clog2(IMG_W)  top-left column of window.
REQ-013 SHALL have port win_vld_o  output  1  window valid.
REQ-014 SHALL have port win_rdy_i  input  1  consumer ready; transfer when win_vld_o&&win_rdy_i.
REQ-015 SHALL have port frame_done_o  output  1  one-cycle pulse on transfer of last window of a frame.

Function
REQ-016 SHALL keep input counters row/col; each accepted pixel is (row,col); col wraps IMG_W-1->0 with row+1; row wraps IMG_H-1->0 (back-to-back frames, no gap required).
REQ-017 SHALL hold two line buffers of IMG_W x DATA_W (rows row-2, row-1) and a 3x3 register window.
REQ-018 On accepted pixel: SHALL read column c of both line buffers, shift column {lb_old[c], lb_new[c], data_i} into window right side, write lb_old[c]<=lb_new[c], lb_new[c]<=data_i.
REQ-019 SHALL assert win_vld_o the cycle after accepting pixel with row>=2 and col>=2; win_row_o=row-2, win_col_o=col-2; latency exactly 1 cycle.
REQ-020 Windows never straddle rows: pixels with col<2 or row<2 SHALL update state but produce no window.
REQ-021 data_rdy_o SHALL equal !win_vld_o || win_rdy_i (single output slot, no bubble under continuous flow).
REQ-022 While win_vld_o&&!win_rdy_i, win_o, win_row_o, win_col_o SHALL stay stable and no pixel is accepted.
REQ-023 win_vld_o SHALL clear after transfer unless a new window is produced the same cycle.
REQ-024 Per frame exactly (IMG_W-2)*(IMG_H-2) windows SHALL be emitted.
REQ-025 frame_done_o SHALL pulse the cycle after transfer of window (IMG_H-3, IMG_W-3).
REQ-026 clear_i SHALL zero counters and win_vld_o next cycle, discard pending window, block acceptance that cycle; line buffer contents need not be cleared (rows 0-1 rewrite them).
REQ-027 clear_i and an accepted transfer same cycle: clear wins; frame_done_o not pulsed.

Reset
REQ-028 On rst: row, col, win_vld_o, frame_done_o, win_o, win_row_o, win_col_o SHALL be 0; data_rdy_o SHALL be 1 from first cycle after reset.
REQ-029 Reset mid-frame SHALL discard partial frame; next accepted pixel is (0,0).
REQ-030 Line buffer RAM SHALL not require reset.

Configuration
REQ-031 Macro WINDOW_GEN_DBG_EN defined: SHALL add outputs dbg_row_o (clog2(IMG_H)) and dbg_col_o (clog2(IMG_W)) showing live input counters, and dbg_stall_o=win_vld_o&&!win_rdy_i.
REQ-032 Macro WINDOW_GEN_DBG_EN undefined: those ports and logic SHALL be absent; all other behaviour identical.

Verification (IMG_W=5, IMG_H=4, DATA_W=8, pixel=row*16+col)
REQ-033 Reset: assert rst 2 cycles -> all outputs 0, data_rdy_o=1, win_vld_o=0 after release.
REQ-034 Continuous frame, win_rdy_i=1 -> first win_vld_o cycle after pixel 0x22 accepted, win_o elements (0,0)..(2,2)=0x00,01,02,10,11,12,20,21,22, row/col=0/0; 6 windows; frame_done_o with window (1,2).
REQ-035 Backpressure: win_rdy_i=0 for 4 cycles at window (0,1) -> data_rdy_o=0, win_o stable, no pixel lost; sequence resumes with (0,2).
REQ-036 Two frames back-to-back -> 12 windows total, second frame first window (0,0) center value 0x11, no window from rows 0-1.
REQ-037 clear_i after pixel 0x13 -> win_vld_o=0 next cycle, next pixel counted (0,0), next window after 13 pixels.
REQ-038 With WINDOW_GEN_DBG_EN: dbg_col_o/dbg_row_o track 0..4/0..3, dbg_stall_o=1 exactly during REQ-035 stall.

Source files
------------

// File: rtl/window_gen_if.sv
// Pixel-in / window-out handshake bundle for window_gen.
interface window_gen_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 540,
  parameter int IMG_H  = 540
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [DATA_W-1:0]   data_i;
  logic                data_en_i;
  logic                data_rdy_o;
  logic [9*DATA_W-1:0] win_o;
  logic [RW-1:0]       win_row_o;
  logic [CW-1:0]       win_col_o;
  logic                win_vld_o;
  logic                win_rdy_i;
  logic                frame_done_o;

  modport master (
    output data_i, data_en_i, win_rdy_i,
    input  data_rdy_o, win_o, win_row_o, win_col_o, win_vld_o, frame_done_o
  );

  modport slave (
    input  data_i, data_en_i, win_rdy_i,
    output data_rdy_o, win_o, win_row_o, win_col_o, win_vld_o, frame_done_o
  );
endinterface

// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream with two line buffers.
// Optional debug ports (live counters, stall flag) enabled by WINDOW_GEN_DBG_EN.
module window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 540,
  parameter int IMG_H  = 540
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
`ifdef WINDOW_GEN_DBG_EN
  output logic [$clog2(IMG_H)-1:0]   dbg_row_o,
  output logic [$clog2(IMG_W)-1:0]   dbg_col_o,
  output logic                       dbg_stall_o,
`endif
  window_gen_if.slave                bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] WROW_LAST = RW'(IMG_H - 3);
  localparam logic [CW-1:0] WCOL_LAST = CW'(IMG_W - 3);

  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [DATA_W-1:0] lb_old [IMG_W];
  logic [DATA_W-1:0] lb_new [IMG_W];
  logic [DATA_W-1:0] win_q  [3][3];
  logic [RW-1:0]     wrow_q;
  logic [CW-1:0]     wcol_q;
  logic              vld_q;
  logic              fd_q;

  logic rdy;
  logic accept;
  logic xfer;
  logic produce;
  logic xfer_last;

  // clear_i suppresses both acceptance and transfer so a flush always wins
  assign rdy       = !vld_q || bus.win_rdy_i;
  assign accept    = bus.data_en_i && rdy && !clear_i;
  assign xfer      = vld_q && bus.win_rdy_i && !clear_i;
  assign produce   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign xfer_last = xfer && (wrow_q == WROW_LAST) && (wcol_q == WCOL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      vld_q  <= 1'b0;
      fd_q   <= 1'b0;
      wrow_q <= '0;
      wcol_q <= '0;
      for (int unsigned i = 0; i < 3; i++)
        for (int unsigned j = 0; j < 3; j++)
          win_q[i][j] <= '0;
    end else if (clear_i) begin
      row_q <= '0;
      col_q <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= xfer_last;
      if (produce) begin
        vld_q  <= 1'b1;
        wrow_q <= row_q - RW'(2);
        wcol_q <= col_q - CW'(2);
      end else if (bus.win_rdy_i) begin
        vld_q <= 1'b0;
      end
      if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        for (int unsigned i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb_old[col_q];
        win_q[1][2] <= lb_new[col_q];
        win_q[2][2] <= bus.data_i;
      end
    end
  end

  // Line buffers carry no reset; rows 0-1 of every frame overwrite them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col_q] <= lb_new[col_q];
      lb_new[col_q] <= bus.data_i;
    end
  end

  always_comb begin
    bus.win_o = '0;
    for (int unsigned i = 0; i < 3; i++)
      for (int unsigned j = 0; j < 3; j++)
        bus.win_o[(3*i+j)*DATA_W +: DATA_W] = win_q[i][j];
  end

  assign bus.data_rdy_o   = rdy;
  assign bus.win_vld_o    = vld_q;
  assign bus.win_row_o    = wrow_q;
  assign bus.win_col_o    = wcol_q;
  assign bus.frame_done_o = fd_q;

`ifdef WINDOW_GEN_DBG_EN
  assign dbg_row_o   = row_q;
  assign dbg_col_o   = col_q;
  assign dbg_stall_o = vld_q && !bus.win_rdy_i;
`endif
endmodule
